// File: rtl/sprite_state_writer.sv
// Per-frame game-state engine: on each vsync fall it advances Mario and the obstacle,
// checks for collision, and burst-writes seven state words into system memory.
module sprite_state_writer #(
    parameter int unsigned SYS_DATA_WIDTH = 18,
    parameter int unsigned SYS_ADDR_WIDTH = 16,
    parameter int unsigned BASE_ADDR      = 'h0050,
    parameter int unsigned X_START        = 64,
    parameter int unsigned X_MAX          = 544,
    parameter int unsigned Y_GROUND       = 400,
    parameter int unsigned RUN_SPEED      = 2,
    parameter int unsigned OBS_SPEED      = 3,
    parameter int unsigned JUMP_V         = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      vsync,
    input  logic                      btn_left,
    input  logic                      btn_right,
    input  logic                      btn_jump,
    output logic [SYS_ADDR_WIDTH-1:0] sys_addr,
    output logic [SYS_DATA_WIDTH-1:0] sys_wr_data,
    output logic                      sys_we,
    output logic                      hit
);

    localparam int unsigned PW = 10;

    localparam logic [PW-1:0]             LP_X_START  = PW'(X_START);
    localparam logic [PW-1:0]             LP_X_MAX    = PW'(X_MAX);
    localparam logic [PW-1:0]             LP_Y_GROUND = PW'(Y_GROUND);
    localparam logic [PW-1:0]             LP_RUN      = PW'(RUN_SPEED);
    localparam logic [PW-1:0]             LP_OBS      = PW'(OBS_SPEED);
    localparam logic [PW-1:0]             LP_HIT_R    = PW'(32);
    localparam logic [5:0]                LP_JUMP_V   = 6'(JUMP_V);
    localparam logic [SYS_ADDR_WIDTH-1:0] LP_BASE     = SYS_ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [3:0] {
        S_IDLE, S_UPDATE,
        S_WR0, S_WR1, S_WR2, S_WR3, S_WR4, S_WR5, S_WR6,
        S_WAIT
    } state_t;

    state_t r_state;

    logic [1:0] r_btn_l, r_btn_r, r_btn_j;
    logic       r_vs_q;

    logic [PW-1:0] r_mx, r_my, r_ox;
    logic [1:0]    r_mm;
    logic [5:0]    r_vel;
    logic          r_air, r_om, r_hit;
    logic [7:0]    r_fc;

    logic                      r_we;
    logic [SYS_ADDR_WIDTH-1:0] r_addr;
    logic [SYS_DATA_WIDTH-1:0] r_data;

    logic                w_frame_start, w_jump;
    logic                w_go_left, w_go_right;
    logic [PW-1:0]       w_mx_nx, w_y_nx, w_ox_nx, w_dx, w_dy;
    logic [5:0]          w_vel_st, w_vel_nx;
    logic                w_air_st, w_air_nx, w_om_nx, w_hit_nx;
    logic [1:0]          w_mm_nx;
    logic [7:0]          w_fc_nx;
    logic signed [PW:0]  w_y_sum;

    logic [PW-1:0]             w_mx_ld, w_my_ld, w_ox_ld;
    logic [1:0]                w_mm_ld;
    logic [5:0]                w_vel_ld;
    logic                      w_air_ld, w_om_ld, w_hit_ld;
    logic [7:0]                w_fc_ld;
    logic [SYS_DATA_WIDTH-1:0] w_word_nx;

    assign w_frame_start = ~vsync & r_vs_q;
    assign w_jump        = r_btn_j[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_btn_l <= '0;
            r_btn_r <= '0;
            r_btn_j <= '0;
            r_vs_q  <= 1'b1;
        end else begin
            r_btn_l <= {r_btn_l[0], btn_left};
            r_btn_r <= {r_btn_r[0], btn_right};
            r_btn_j <= {r_btn_j[0], btn_jump};
            r_vs_q  <= vsync;
        end
    end

    always_comb begin
        w_go_left  = r_btn_l[1] & ~r_btn_r[1];
        w_go_right = r_btn_r[1] & ~r_btn_l[1];

        w_mx_nx = r_mx;
        if (w_go_left)
            w_mx_nx = (r_mx < LP_RUN) ? '0 : r_mx - LP_RUN;
        else if (w_go_right)
            w_mx_nx = (r_mx > LP_X_MAX - LP_RUN) ? LP_X_MAX : r_mx + LP_RUN;

        // A jump launched this frame also takes its first airborne step this frame.
        w_vel_st = r_vel;
        w_air_st = r_air;
        if (!r_air && w_jump) begin
            w_vel_st = -LP_JUMP_V;
            w_air_st = 1'b1;
        end
        w_y_sum  = $signed({1'b0, r_my}) + $signed({{(PW-5){w_vel_st[5]}}, w_vel_st});
        w_y_nx   = r_my;
        w_vel_nx = w_vel_st;
        w_air_nx = w_air_st;
        if (w_air_st) begin
            if (w_y_sum >= $signed({1'b0, LP_Y_GROUND})) begin
                w_y_nx   = LP_Y_GROUND;
                w_vel_nx = '0;
                w_air_nx = 1'b0;
            end else begin
                w_y_nx   = w_y_sum[PW-1:0];
                w_vel_nx = w_vel_st + 6'd1;
            end
        end

        if (w_air_nx)
            w_mm_nx = 2'd3;
        else if (w_go_left | w_go_right)
            w_mm_nx = (r_fc[2:0] == 3'd7) ? r_mm + 2'd1 : r_mm;
        else
            w_mm_nx = '0;

        w_ox_nx = (r_ox < LP_OBS) ? LP_X_MAX : r_ox - LP_OBS;
        w_om_nx = (r_fc[3:0] == 4'hF) ? ~r_om : r_om;
        w_fc_nx = r_fc + 8'd1;

        w_dx     = (w_mx_nx >= w_ox_nx) ? w_mx_nx - w_ox_nx : w_ox_nx - w_mx_nx;
        w_dy     = (w_y_nx >= LP_Y_GROUND) ? w_y_nx - LP_Y_GROUND : LP_Y_GROUND - w_y_nx;
        w_hit_nx = (w_dx < LP_HIT_R) && (w_dy < LP_HIT_R);
    end

    always_comb begin
        w_mx_ld  = w_mx_nx;
        w_my_ld  = w_y_nx;
        w_mm_ld  = w_mm_nx;
        w_vel_ld = w_vel_nx;
        w_air_ld = w_air_nx;
        w_ox_ld  = w_ox_nx;
        w_om_ld  = w_om_nx;
        w_fc_ld  = w_fc_nx;
        w_hit_ld = w_hit_nx;
        if (r_hit) begin
            if (w_jump) begin
                w_mx_ld  = LP_X_START;
                w_my_ld  = LP_Y_GROUND;
                w_mm_ld  = '0;
                w_vel_ld = '0;
                w_air_ld = 1'b0;
                w_ox_ld  = LP_X_MAX;
                w_om_ld  = 1'b0;
                w_fc_ld  = '0;
                w_hit_ld = 1'b0;
            end else begin
                w_mx_ld  = r_mx;
                w_my_ld  = r_my;
                w_mm_ld  = r_mm;
                w_vel_ld = r_vel;
                w_air_ld = r_air;
                w_ox_ld  = r_ox;
                w_om_ld  = r_om;
                w_fc_ld  = r_fc;
                w_hit_ld = r_hit;
            end
        end
    end

    // Data for the word written in the following WR state, from the updated registers.
    always_comb begin
        w_word_nx = '0;
        case (r_state)
            S_WR0:   w_word_nx = SYS_DATA_WIDTH'(r_my);
            S_WR1:   w_word_nx = SYS_DATA_WIDTH'(r_mm);
            S_WR2:   w_word_nx = SYS_DATA_WIDTH'(r_ox);
            S_WR3:   w_word_nx = SYS_DATA_WIDTH'(LP_Y_GROUND);
            S_WR4:   w_word_nx = SYS_DATA_WIDTH'(r_om);
            S_WR5:   w_word_nx = SYS_DATA_WIDTH'({r_hit, r_fc});
            default: w_word_nx = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_mx    <= LP_X_START;
            r_my    <= LP_Y_GROUND;
            r_mm    <= '0;
            r_vel   <= '0;
            r_air   <= 1'b0;
            r_ox    <= LP_X_MAX;
            r_om    <= 1'b0;
            r_fc    <= '0;
            r_hit   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_frame_start)
                        r_state <= S_UPDATE;
                end
                S_UPDATE: begin
                    r_mx    <= w_mx_ld;
                    r_my    <= w_my_ld;
                    r_mm    <= w_mm_ld;
                    r_vel   <= w_vel_ld;
                    r_air   <= w_air_ld;
                    r_ox    <= w_ox_ld;
                    r_om    <= w_om_ld;
                    r_fc    <= w_fc_ld;
                    r_hit   <= w_hit_ld;
                    r_we    <= 1'b1;
                    r_addr  <= LP_BASE;
                    r_data  <= SYS_DATA_WIDTH'(w_mx_ld);
                    r_state <= S_WR0;
                end
                S_WR0, S_WR1, S_WR2, S_WR3, S_WR4, S_WR5: begin
                    r_addr  <= r_addr + SYS_ADDR_WIDTH'(1);
                    r_data  <= w_word_nx;
                    r_state <= state_t'(r_state + 4'd1);
                end
                S_WR6: begin
                    r_we    <= 1'b0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (vsync)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sys_we      = r_we;
    assign sys_addr    = r_addr;
    assign sys_wr_data = r_data;
    assign hit         = r_hit;

endmodule

// File: tb/tb_sprite_state_writer.sv
// Randomized self-checking bench for sprite_state_writer against a frame-level game model.
module tb_sprite_state_writer;

    logic        clk;
    logic        reset;
    logic        vsync;
    logic        btn_left, btn_right, btn_jump;
    logic [15:0] sys_addr;
    logic [17:0] sys_wr_data;
    logic        sys_we;
    logic        hit;

    int n_cmp = 0;
    int n_err = 0;

    int m_mx, m_my, m_mm, m_vel, m_air, m_ox, m_om, m_fc, m_hit;

    sprite_state_writer dut (
        .clk         (clk),
        .reset       (reset),
        .vsync       (vsync),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_jump    (btn_jump),
        .sys_addr    (sys_addr),
        .sys_wr_data (sys_wr_data),
        .sys_we      (sys_we),
        .hit         (hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic model_reset();
        m_mx = 64; m_my = 400; m_mm = 0; m_vel = 0; m_air = 0;
        m_ox = 544; m_om = 0; m_fc = 0; m_hit = 0;
    endtask

    // One frame of game rules, written directly from the behavioural description.
    task automatic model_step(input logic l, input logic r, input logic j);
        int nmx, ny, nvel, nair, nmm, nox, dx, dy;
        if (m_hit != 0) begin
            if (j) model_reset();
            return;
        end
        nmx = m_mx;
        if (l && !r) nmx = (m_mx - 2 < 0) ? 0 : m_mx - 2;
        if (r && !l) nmx = (m_mx + 2 > 544) ? 544 : m_mx + 2;
        ny = m_my; nvel = m_vel; nair = m_air;
        if (nair == 0 && j) begin
            nvel = -12;
            nair = 1;
        end
        if (nair != 0) begin
            ny   = m_my + nvel;
            nvel = nvel + 1;
            if (ny >= 400) begin
                ny = 400; nvel = 0; nair = 0;
            end
        end
        if (nair != 0)      nmm = 3;
        else if (l != r)    nmm = (m_fc % 8 == 7) ? (m_mm + 1) % 4 : m_mm;
        else                nmm = 0;
        nox = (m_ox < 3) ? 544 : m_ox - 3;
        if (m_fc % 16 == 15) m_om = 1 - m_om;
        m_fc = (m_fc + 1) % 256;
        m_mx = nmx; m_my = ny; m_vel = nvel; m_air = nair; m_mm = nmm; m_ox = nox;
        dx = (m_mx > m_ox) ? m_mx - m_ox : m_ox - m_mx;
        dy = (m_my > 400) ? m_my - 400 : 400 - m_my;
        m_hit = (dx < 32 && dy < 32) ? 1 : 0;
    endtask

    // Runs one frame; rise_at/relow_at are the sample indices after which vsync goes high/low again.
    task automatic run_frame(input logic l, input logic r, input logic j,
                             input int rise_at, input int relow_at);
        int          nw, first, last;
        int          expw [7];
        logic [15:0] a [7];
        logic [17:0] d [7];
        btn_left = l; btn_right = r; btn_jump = j;
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        nw = 0; first = -1; last = -1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (sys_we === 1'b1) begin
                if (nw < 7) begin
                    a[nw] = sys_addr;
                    d[nw] = sys_wr_data;
                end
                if (first < 0) first = k;
                last = k;
                nw++;
            end
            if (k == rise_at)  vsync = 1'b1;
            if (k == relow_at) vsync = 1'b0;
        end
        vsync = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_step(l, r, j);
        expw[0] = m_mx; expw[1] = m_my; expw[2] = m_mm; expw[3] = m_ox;
        expw[4] = 400;  expw[5] = m_om; expw[6] = m_hit * 256 + m_fc;
        chk("we_count", nw, 7);
        chk("we_first_cycle", first, 2);
        chk("we_last_cycle", last, 8);
        for (int i = 0; i < 7; i++) begin
            if (i < nw) begin
                chk($sformatf("addr%0d", i), a[i], 32'h50 + i);
                chk($sformatf("word%0d", i), d[i], expw[i]);
            end
        end
        chk("hit", hit, m_hit);
    endtask

    initial begin
        int dgap;
        logic l, r, j;
        reset = 1'b0; vsync = 1'b1;
        btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
        #1;
        chk("rst_we", sys_we, 0);
        chk("rst_addr", sys_addr, 0);
        chk("rst_data", sys_wr_data, 0);
        chk("rst_hit", hit, 0);
        @(negedge clk);
        reset = 1'b1;

        run_frame(0, 0, 0, 10, 0);
        chk("first_obs_x", m_ox, 541);

        for (int n = 0; n < 40; n++) run_frame(1, 0, 0, 10, 0);
        chk("left_saturated", m_mx, 0);

        for (int n = 0; n < 200 && m_hit == 0; n++) run_frame(0, 0, 0, 10, 0);
        chk("collision_reached", hit, 1);
        for (int n = 0; n < 3; n++) run_frame(0, 0, 0, 10, 0);
        run_frame(0, 0, 1, 10, 0);
        chk("hit_cleared_by_jump", hit, 0);

        for (int n = 0; n < 30; n++) run_frame(0, 0, 1, 10, 0);

        btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("wr3_we", sys_we, 1);
        chk("wr3_addr", sys_addr, 32'h53);
        reset = 1'b0;
        #1;
        chk("async_rst_we", sys_we, 0);
        chk("async_rst_addr", sys_addr, 0);
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        run_frame(0, 0, 0, 10, 0);

        run_frame(0, 1, 0, 4, 0);
        run_frame(0, 1, 0, 3, 5);
        run_frame(0, 1, 0, 10, 0);

        for (int n = 0; n < 350; n++) begin
            l = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 7) != 0);
            j = ($urandom_range(0, 15) == 0);
            dgap = m_ox - m_mx;
            if (m_air == 0 && dgap >= 40 && dgap <= 48) j = 1'b1;
            if (m_hit != 0) j = 1'b1;
            run_frame(l, r, j, $urandom_range(1, 12), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
